// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman datapath front end: character width, PS/2 scancode
// constants, the PS/2 frame receiver state type and the scancode-to-letter map.
package hangman_pkg;

  localparam int unsigned CHAR_W = 5;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } frame_state_e;

  // Set-2 make code to letter code A=1 .. Z=26; 0 for anything that is not a letter.
  function automatic logic [CHAR_W-1:0] sc_to_letter(input logic [7:0] sc);
    case (sc)
      8'h1C:   return 5'd1;
      8'h32:   return 5'd2;
      8'h21:   return 5'd3;
      8'h23:   return 5'd4;
      8'h24:   return 5'd5;
      8'h2B:   return 5'd6;
      8'h34:   return 5'd7;
      8'h33:   return 5'd8;
      8'h43:   return 5'd9;
      8'h3B:   return 5'd10;
      8'h42:   return 5'd11;
      8'h4B:   return 5'd12;
      8'h3A:   return 5'd13;
      8'h31:   return 5'd14;
      8'h44:   return 5'd15;
      8'h4D:   return 5'd16;
      8'h15:   return 5'd17;
      8'h2D:   return 5'd18;
      8'h1B:   return 5'd19;
      8'h2C:   return 5'd20;
      8'h3C:   return 5'd21;
      8'h2A:   return 5'd22;
      8'h1D:   return 5'd23;
      8'h22:   return 5'd24;
      8'h35:   return 5'd25;
      8'h1A:   return 5'd26;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_dat, detects falling edges of the PS/2 clock
// and assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, resetn        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat   raw asynchronous PS/2 lines
//   rx_byte            last received data byte (valid with byte_valid)
//   byte_valid         one-cycle strobe for a good frame
//   frame_err          one-cycle strobe on parity/stop error or inter-edge timeout
module ps2_frame_rx
  import hangman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   dat_s;
  logic                   frame_ok;

  frame_state_e  state;
  logic [3:0]    bitcnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;

  // Lines idle high, so reset the synchronisers to 1 to avoid a false edge out of reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // shreg holds {stop, parity, data[7:0]} once all ten post-start bits are in.
  assign frame_ok = (^shreg[8:0]) & shreg[9];

  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= StIdle;
      bitcnt     <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        StIdle: begin
          to_cnt <= '0;
          if (fall && !dat_s) begin
            state  <= StShift;
            bitcnt <= 4'd1;
          end
        end
        StShift: begin
          if (fall) begin
            to_cnt <= '0;
            shreg  <= {dat_s, shreg[9:1]};
            if (bitcnt == 4'd10) begin
              state  <= StCheck;
              bitcnt <= '0;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= StIdle;
            bitcnt    <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        StCheck: begin
          if (frame_ok) begin
            rx_byte    <= shreg[7:0];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/ps2_char_decoder.sv
// PS/2 keyboard front end for the hangman datapath. Decodes make codes into letter codes
// (A=1 .. Z=26) and single-cycle strobes for letter, Enter and Backspace.
// Optional feature macro: REPEAT_FILTER_EN suppresses typematic repeats of a held key.
// Ports:
//   clk, resetn        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat   raw asynchronous PS/2 lines
//   char               last decoded letter code, 0 after reset
//   char_valid         one-cycle strobe, char updated with it
//   enter, backspace   one-cycle key strobes
//   frame_err          one-cycle strobe on a bad or timed-out frame
module ps2_char_decoder
  import hangman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              enter,
  output logic              backspace,
  output logic              frame_err
);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              brk;
  logic              ext;
  logic              is_code;
  logic              is_make;
  logic              suppress;
  logic [CHAR_W-1:0] letter;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign letter  = sc_to_letter(rx_byte);
  // A non-prefix byte ends a code sequence; it is a make unless a break prefix preceded it.
  assign is_code = byte_valid && (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);
  assign is_make = is_code && !brk;

`ifdef REPEAT_FILTER_EN
  logic [8:0] code;
  logic [8:0] held;
  logic       held_v;

  assign code     = {ext, rx_byte};
  assign suppress = held_v && (held == code);

  always_ff @(posedge clk) begin
    if (resetn) begin
      held   <= '0;
      held_v <= 1'b0;
    end else if (is_make) begin
      held   <= code;
      held_v <= 1'b1;
    end else if (is_code && held_v && (held == code)) begin
      held_v <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      char       <= '0;
      char_valid <= 1'b0;
      enter      <= 1'b0;
      backspace  <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      enter      <= 1'b0;
      backspace  <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (is_make && !suppress) begin
            if (rx_byte == SC_ENTER) begin
              enter <= 1'b1;
            end else if (!ext) begin
              if (rx_byte == SC_BKSP) begin
                backspace <= 1'b1;
              end else if (letter != '0) begin
                char       <= letter;
                char_valid <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_char_decoder.sv
// Bench for ps2_char_decoder: scoreboard of expected strobes fed by a byte-level model,
// checked by an independent monitor whenever the DUT strobes.
module tb_ps2_char_decoder;

  localparam int HALF = 8;  // PS/2 half period in system clocks

  typedef struct {
    int kind;  // 0 letter, 1 enter, 2 backspace, 3 frame error
    int ch;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] char;
  logic       char_valid;
  logic       enter;
  logic       backspace;
  logic       frame_err;

  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  int   last_char = 0;

  bit   m_brk = 0;
  bit   m_ext = 0;
  int   held = -1;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  ps2_char_decoder #(
    .TIMEOUT_CYCLES(100),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .char      (char),
    .char_valid(char_valid),
    .enter     (enter),
    .backspace (backspace),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (letters[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic push(input int kind, input int ch);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Keyboard-protocol model: prefixes, break/make, extended keys, optional repeat filter.
  task automatic model_byte(input logic [7:0] b);
    int code;
    bit sup;
    int lk;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      code = (m_ext ? 256 : 0) + int'(b);
      sup  = 0;
      if (m_brk) begin
        if (held == code) held = -1;
      end else begin
`ifdef REPEAT_FILTER_EN
        sup  = (held == code);
        held = code;
`endif
        if (!sup) begin
          lk = lookup(b);
          if (b == 8'h5A) push(1, 0);
          else if (!m_ext && b == 8'h66) push(2, 0);
          else if (!m_ext && lk != 0) push(0, lk);
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int tail);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cycles(tail);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip);
    logic par;
    par = ~(^b) ^ flip;
    if (flip) push(3, 0);
    else model_byte(b);
    send_bits({1'b1, par, b, 1'b0}, 11, 20);
  endtask

  task automatic check_quiet(input string name);
    check(name, int'({char, char_valid, enter, backspace, frame_err}), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    check_quiet("outputs in reset");
    #1 resetn = 1'b0;
    m_brk = 0;
    m_ext = 0;
    held = -1;
    last_char = 0;
    wait_cycles(2);
  endtask

  // Monitor: pops one expectation per observed strobe.
  initial begin
    exp_t e;
    int   nstr;
    int   kind;
    forever begin
      @(negedge clk);
      if (!resetn && (char_valid | enter | backspace | frame_err)) begin
        nstr = int'(char_valid) + int'(enter) + int'(backspace) + int'(frame_err);
        check("strobe exclusivity", nstr, 1);
        kind = char_valid ? 0 : enter ? 1 : backspace ? 2 : 3;
        if (exp_q.size() == 0) begin
          check("unexpected strobe kind", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check("strobe kind", kind, e.kind);
          if (e.kind == 0) last_char = e.ch;
          check("char value", int'(char), last_char);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // Letter make then its break.
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    // Enter, extended Enter, Backspace.
    send_byte(8'h5A, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h66, 0);
    // Parity error then good frame.
    send_byte(8'h1A, 1);
    send_byte(8'h1A, 0);
    // Truncated frame times out.
    push(3, 0);
    send_bits({1'b1, 1'b0, 8'h21, 1'b0}, 5, 150);
    send_byte(8'h21, 0);
    // Reset in the middle of a frame.
    send_bits({1'b1, 1'b1, 8'h24, 1'b0}, 6, 0);
    do_reset();
    send_byte(8'h24, 0);
    // Typematic repeats.
    send_byte(8'h1C, 0);
    send_byte(8'h1C, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    send_byte(8'h1C, 0);
    // Randomised byte stream.
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [7:0]  b;
      r = $urandom_range(0, 9);
      if (r < 5) b = letters[$urandom_range(0, 25)];
      else if (r == 5) b = 8'hF0;
      else if (r == 6) b = 8'hE0;
      else if (r == 7) b = 8'h5A;
      else if (r == 8) b = 8'h66;
      else b = 8'($urandom);
      send_byte(b, $urandom_range(0, 9) == 0);
    end
    wait_cycles(50);
    check("pending expectations", exp_q.size(), 0);
    check("final char", int'(char), last_char);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
